out_port_ctrl: RTL

OUT_PORT_CTRL -- requirements
Module: out_port_ctrl

---
 rtl/out_port_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/out_port_ctrl.sv
// Output port controller: display register plus a FIFO drained over valid/ready.
// Define OUT_PORT_STALL_EN to stall the CPU on a full FIFO instead of dropping writes.
module out_port_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_o,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_val,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  stall,
  output logic [CW-1:0]         fifo_count
);

  typedef enum logic {IDLE, PRESENT} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] out_val_q, out_val_d;
  logic                  full;
  logic                  pop;
  logic                  accept;

  assign full   = (count_q == CW'(DEPTH));
  assign pop    = (state_q == PRESENT) && out_ready;
  assign accept = load_o && (!full || pop);

`ifdef OUT_PORT_STALL_EN
  assign stall = load_o && full && !pop;
`else
  assign stall = 1'b0;
`endif

  assign out_valid  = (state_q == PRESENT);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_val    = out_val_q;
  assign fifo_count = count_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    out_val_d = out_val_q;
    if (accept) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      out_val_d = bus_in;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    unique case (state_q)
      IDLE:
        if (accept) state_d = PRESENT;
      PRESENT:
        if (pop && !accept && count_q == CW'(1))
          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_val_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      out_val_q <= out_val_d;
    end
  end

  // Storage is deliberately unreset; out_data masks it while empty.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= bus_in;
  end

endmodule
